apb_master_bridge: RTL and testbench

APB initiator that converts single-beat commands from an internal requester (test sequencer, config engine, or CPU shim) into APB SETUP/ACCESS transfers toward the UART's APB slave interface. It returns read data, slave error and a timeout indication per transfer. It holds one transfer in flight and enforces a bounded PREADY wait.

---
 rtl/apb_master_bridge.sv | 143 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: command -> SETUP -> ACCESS -> one-cycle response; 3 cycles accept-to-response plus wait states.
// cmd_ready is low from accept until the response cycle; responses have no backpressure; PREADY waits are bounded by TIMEOUT_CYCLES.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t                state, state_nxt;
  logic [15:0]           wait_cnt, wait_cnt_nxt;
  logic                  cmd_ready_nxt, busy_nxt, psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt, rsp_rdata_nxt;
  logic                  rsp_valid_nxt, rsp_error_nxt, rsp_timeout_nxt;
  logic [15:0]           wait_inc;

  assign wait_inc = wait_cnt + 16'd1;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      cmd_ready   <= cmd_ready_nxt;
      busy        <= busy_nxt;
      PSELx       <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_error   <= rsp_error_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  // Every output is computed one cycle early here so the flops above present it registered.
  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    cmd_ready_nxt   = cmd_ready;
    busy_nxt        = busy;
    psel_nxt        = PSELx;
    penable_nxt     = PENABLE;
    pwrite_nxt      = PWRITE;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_error_nxt   = rsp_error;
    rsp_timeout_nxt = rsp_timeout;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt     = SETUP;
          cmd_ready_nxt = 1'b0;
          busy_nxt      = 1'b1;
          psel_nxt      = 1'b1;
          penable_nxt   = 1'b0;
          pwrite_nxt    = cmd_write;
          paddr_nxt     = cmd_addr;
          pwdata_nxt    = cmd_wdata;
        end
      end
      SETUP: begin
        state_nxt    = ACCESS;
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          state_nxt       = IDLE;
          cmd_ready_nxt   = 1'b1;
          busy_nxt        = 1'b0;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
          rsp_error_nxt   = PSLVERR;
          rsp_timeout_nxt = 1'b0;
        end else if (TO_EN && (wait_inc == TO_LIMIT)) begin
          // This is the K-th stalled ACCESS cycle; PREADY=1 above already took priority.
          state_nxt       = IDLE;
          cmd_ready_nxt   = 1'b1;
          busy_nxt        = 1'b0;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_error_nxt   = 1'b1;
          rsp_timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge built with TIMEOUT_CYCLES=4; the bench acts as the APB slave.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        busy;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int tests = 0;
  int fails = 0;

  apb_master_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;      // ACCESS cycles with PREADY low before it rises; 255 = never
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;    // cycles from accept edge to rsp_valid
    int          exp_pen;    // cycles with PENABLE high
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  waited, lat, pen, bad_hold, setup_ok;
    bit  done;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    PRDATA    = v.prdata;
    PSLVERR   = v.slverr;
    PREADY    = 1'b0;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge PCLK);
      waited++;
    end
    chk($sformatf("v%0d cmd_ready before accept", idx), cmd_ready, 1'b1);
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    lat = 0; pen = 0; bad_hold = 0; setup_ok = 0; done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge PCLK);
      if (c == 1)
        setup_ok = int'(PSELx && !PENABLE && busy && !cmd_ready);
      if (PSELx && (PADDR !== v.addr || PWRITE !== v.write || (v.write && PWDATA !== v.wdata)))
        bad_hold++;
      if (PSELx && PENABLE) begin
        pen++;
        PREADY = (pen > v.waits);
      end else begin
        PREADY = 1'b0;
      end
      if (rsp_valid) begin
        done = 1;
        lat  = c;
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d rsp_error", idx), rsp_error, v.exp_err);
        chk($sformatf("v%0d rsp_timeout", idx), rsp_timeout, v.exp_to);
        chk($sformatf("v%0d idle at rsp (psel,pen,ready,busy)", idx),
            {PSELx, PENABLE, cmd_ready, busy}, 4'b0010);
      end
    end
    PREADY = 1'b0;
    chk($sformatf("v%0d setup phase", idx), setup_ok, 1);
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d penable cycles", idx), pen, v.exp_pen);
    chk($sformatf("v%0d addr/dir/data hold errors", idx), bad_hold, 0);
    @(negedge PCLK);
    chk($sformatf("v%0d rsp_valid one-cycle", idx), rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] psel_seq, rsp_seq;
    logic [31:0] addr2_seen, rdata1, rdata2;
    int rsp_during_rst;

    //              wr  addr   wdata  prdata       err waits  exp_rdata  err to lat pen
    vecs[0] = '{1'b0, 32'h08, 32'h0, 32'hA5,       1'b0, 0,   32'hA5,    1'b0, 1'b0, 3, 1};
    vecs[1] = '{1'b1, 32'h00, 32'h55, 32'hDEADBEEF,1'b0, 3,   32'h0,     1'b0, 1'b0, 6, 4};
    vecs[2] = '{1'b0, 32'h10, 32'h0, 32'h1234,     1'b1, 1,   32'h1234,  1'b1, 1'b0, 4, 2};
    vecs[3] = '{1'b0, 32'h14, 32'h0, 32'hCAFE,     1'b0, 255, 32'h0,     1'b1, 1'b1, 6, 4};
    vecs[4] = '{1'b0, 32'h18, 32'h0, 32'h77,       1'b0, 3,   32'h77,    1'b0, 1'b0, 6, 4};
    vecs[5] = '{1'b1, 32'h1C, 32'hF00D, 32'h99,    1'b0, 255, 32'h0,     1'b1, 1'b1, 6, 4};
    vecs[6] = '{1'b1, 32'h04, 32'h3C, 32'h11,      1'b1, 0,   32'h0,     1'b1, 1'b0, 3, 1};

    // Reset state
    #12;
    chk("reset apb ctrl (psel,pen,pwrite)", {PSELx, PENABLE, PWRITE}, 3'b000);
    chk("reset paddr", PADDR, 32'h0);
    chk("reset pwdata", PWDATA, 32'h0);
    chk("reset rsp (valid,err,to,busy)", {rsp_valid, rsp_error, rsp_timeout, busy}, 4'b0000);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset cmd_ready", cmd_ready, 1'b1);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Back-to-back: cmd_valid held across two commands, zero wait states.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; PRDATA = 32'h1111;
    PSLVERR = 1'b0; PREADY = 1'b1;
    @(posedge PCLK);
    #1 cmd_addr = 32'h24;
    psel_seq = '0; rsp_seq = '0; addr2_seen = '0; rdata1 = '0; rdata2 = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge PCLK);
      psel_seq[c-1] = PSELx;
      rsp_seq[c-1]  = rsp_valid;
      if (c == 3) rdata1 = rsp_rdata;
      if (c == 4) begin addr2_seen = PADDR; PRDATA = 32'h2222; end
      if (c == 6) rdata2 = rsp_rdata;
      if (c == 3) begin
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
      end
    end
    PREADY = 1'b0;
    chk("b2b psel pattern", psel_seq, 6'b011011);
    chk("b2b rsp_valid pattern", rsp_seq, 6'b100100);
    chk("b2b second paddr", addr2_seen, 32'h24);
    chk("b2b first rdata", rdata1, 32'h1111);
    chk("b2b second rdata", rdata2, 32'h2222);

    // Reset asserted during ACCESS, between clock edges.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'hABCD;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre-reset in ACCESS (psel,pen)", {PSELx, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("async reset (psel,pen,busy,ready)", {PSELx, PENABLE, busy, cmd_ready}, 4'b0001);
    rsp_during_rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      if (rsp_valid) rsp_during_rst++;
    end
    PRESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      if (rsp_valid || PSELx) rsp_during_rst++;
    end
    chk("no response/activity after reset", rsp_during_rst, 0);
    run_vec(7, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
